// File: rtl/dm_cache_fsm.sv
// Direct-mapped, write-back, write-allocate cache controller.
// One CPU port in front of a line-wide memory. Holds the tag/valid/dirty/data
// arrays and a 4-state FSM that serves hits, writes back dirty victims and
// refills lines. All work after acceptance uses the latched request.
module dm_cache_fsm #(
  parameter int NUM_LINES = 1024,
  parameter int LINE_BITS = 128
) (
  input  logic                 clk,
  input  logic                 rst,       // async, active low
  input  logic [65:0]          cpu_req,   // {addr, data, rw, valid}
  input  logic [LINE_BITS:0]   mem_data,  // {data, ready}
  output logic [LINE_BITS+33:0] mem_req,  // {addr, data, rw, valid}
  output logic [32:0]          cpu_res    // {data, ready}
);

  localparam int IDX_W  = $clog2(NUM_LINES);
  localparam int OFF_W  = $clog2(LINE_BITS / 8);
  localparam int WSEL_W = OFF_W - 2;
  localparam int TAG_W  = 32 - IDX_W - OFF_W;

  typedef enum logic [1:0] {IDLE, COMPARE_TAG, ALLOCATE, WRITE_BACK} state_t;

  // Input bus fields
  logic                 cpu_valid, cpu_rw;
  logic [31:0]          cpu_addr, cpu_wdata;
  logic                 mem_ready;
  logic [LINE_BITS-1:0] mem_rdata;
  logic                 unused_addr_lsb;

  assign cpu_addr  = cpu_req[65:34];
  assign cpu_wdata = cpu_req[33:2];
  assign cpu_rw    = cpu_req[1];
  assign cpu_valid = cpu_req[0];
  assign mem_rdata = mem_data[LINE_BITS:1];
  assign mem_ready = mem_data[0];
  // Byte offset within a word is never used.
  assign unused_addr_lsb = ^cpu_addr[1:0];

  // State
  state_t               state_q, state_d;
  logic [31:2]          req_addr_q;
  logic [31:0]          req_data_q;
  logic                 req_rw_q;
  logic [31:0]          victim_q;
  logic [NUM_LINES-1:0] valid_q, dirty_q;
  logic [TAG_W-1:0]     tag_arr  [NUM_LINES];
  logic [LINE_BITS-1:0] line_arr [NUM_LINES];

  // Latched request decode
  logic [TAG_W-1:0]     req_tag;
  logic [IDX_W-1:0]     req_idx;
  logic [WSEL_W-1:0]    req_word;
  logic [TAG_W-1:0]     cur_tag;
  logic [LINE_BITS-1:0] cur_line;
  logic                 hit;

  assign req_tag  = req_addr_q[31 -: TAG_W];
  assign req_idx  = req_addr_q[OFF_W +: IDX_W];
  assign req_word = req_addr_q[2 +: WSEL_W];
  assign cur_tag  = tag_arr[req_idx];
  assign cur_line = line_arr[req_idx];
  assign hit      = valid_q[req_idx] && (cur_tag == req_tag);

  // Control strobes from the FSM
  logic                 latch_req, miss_upd, set_dirty, line_we;
  logic [LINE_BITS-1:0] line_wdata, merged_line;

  // Output fields
  logic [31:0]          mr_addr;
  logic [LINE_BITS-1:0] mr_data;
  logic                 mr_rw, mr_valid;
  logic [31:0]          cr_data;
  logic                 cr_ready;

  assign mem_req = {mr_addr, mr_data, mr_rw, mr_valid};
  assign cpu_res = {cr_data, cr_ready};

  // Current line with the latched write word merged in
  always_comb begin
    merged_line = cur_line;
    merged_line[req_word*32 +: 32] = req_data_q;
  end

  // Next-state and output decode
  always_comb begin
    state_d    = state_q;
    latch_req  = 1'b0;
    miss_upd   = 1'b0;
    set_dirty  = 1'b0;
    line_we    = 1'b0;
    line_wdata = merged_line;
    mr_addr    = '0;
    mr_data    = '0;
    mr_rw      = 1'b0;
    mr_valid   = 1'b0;
    cr_data    = '0;
    cr_ready   = 1'b0;
    case (state_q)
      IDLE: begin
        if (cpu_valid) begin
          latch_req = 1'b1;
          state_d   = COMPARE_TAG;
        end
      end
      COMPARE_TAG: begin
        if (hit) begin
          cr_ready = 1'b1;
          if (req_rw_q) begin
            cr_data   = req_data_q;
            line_we   = 1'b1;
            set_dirty = 1'b1;
          end else begin
            cr_data = cur_line[req_word*32 +: 32];
          end
          state_d = IDLE;
        end else begin
          // Retag now; the old tag survives in victim_q for the write-back.
          miss_upd = 1'b1;
          state_d  = (valid_q[req_idx] && dirty_q[req_idx]) ? WRITE_BACK : ALLOCATE;
        end
      end
      ALLOCATE: begin
        mr_addr  = {req_addr_q[31:OFF_W], {OFF_W{1'b0}}};
        mr_valid = 1'b1;
        if (mem_ready) begin
          line_we    = 1'b1;
          line_wdata = mem_rdata;
          state_d    = COMPARE_TAG;
        end
      end
      WRITE_BACK: begin
        mr_addr  = victim_q;
        mr_data  = cur_line;
        mr_rw    = 1'b1;
        mr_valid = 1'b1;
        if (mem_ready) state_d = ALLOCATE;
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM, request latch and line status bits
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      req_addr_q <= '0;
      req_data_q <= '0;
      req_rw_q   <= 1'b0;
      victim_q   <= '0;
      valid_q    <= '0;
      dirty_q    <= '0;
    end else begin
      state_q <= state_d;
      if (latch_req) begin
        req_addr_q <= cpu_addr[31:2];
        req_data_q <= cpu_wdata;
        req_rw_q   <= cpu_rw;
      end
      if (miss_upd) begin
        victim_q         <= {cur_tag, req_idx, {OFF_W{1'b0}}};
        valid_q[req_idx] <= 1'b1;
        dirty_q[req_idx] <= 1'b0;
      end
      if (set_dirty) dirty_q[req_idx] <= 1'b1;
    end
  end

  // Tag and data storage, deliberately not reset
  always_ff @(posedge clk) begin
    if (miss_upd) tag_arr[req_idx] <= req_tag;
    if (line_we)  line_arr[req_idx] <= line_wdata;
  end

endmodule

// File: tb/tb_dm_cache_fsm.sv
// Directed bench for dm_cache_fsm with a 2-4 cycle line memory model,
// a queue of expected CPU read data and a log of memory transactions.
module tb_dm_cache_fsm;

  logic         clk;
  logic         rst;
  logic [65:0]  cpu_req;
  logic [128:0] mem_data;
  logic [161:0] mem_req;
  logic [32:0]  cpu_res;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0]  a;
    logic         rw;
    logic [127:0] d;
  } mtx_t;

  logic [127:0] mem [logic [31:0]];
  mtx_t         mlog [$];
  logic [31:0]  exp_q [$];

  logic [127:0] mem_rdata;
  logic         mem_rdy;
  int           mcnt, mlat;

  assign mem_data = {mem_rdata, mem_rdy};

  dm_cache_fsm dut (
    .clk      (clk),
    .rst      (rst),
    .cpu_req  (cpu_req),
    .mem_data (mem_data),
    .mem_req  (mem_req),
    .cpu_res  (cpu_res)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: answers a held request after 2-4 cycles with a 1-cycle ready.
  always @(negedge clk) begin
    mtx_t t;
    mem_rdy = 1'b0;
    if (!rst || !mem_req[0]) begin
      mcnt = 0;
    end else begin
      if (mcnt == 0) mlat = $urandom_range(4, 2);
      mcnt++;
      if (mcnt >= mlat) begin
        t.a  = mem_req[161:130];
        t.d  = mem_req[129:2];
        t.rw = mem_req[1];
        if (t.rw) mem[t.a] = t.d;
        else mem_rdata = mem.exists(t.a) ? mem[t.a] : 128'h0;
        mlog.push_back(t);
        mem_rdy = 1'b1;
        mcnt    = 0;
      end
    end
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Issue one CPU access and compare the response against the scoreboard.
  // hit_exp=1: ready must come one cycle after acceptance; else later.
  task automatic access(input string tag, input logic [31:0] a, input logic [31:0] d,
                        input logic w, input logic [31:0] exp, input logic hit_exp);
    int k;
    logic [31:0] e;
    mlog.delete();
    exp_q.push_back(exp);
    @(negedge clk);
    cpu_req = {a, d, w, 1'b1};
    @(posedge clk);
    #1 cpu_req[0] = 1'b0;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!cpu_res[0] && k < 60);
    check({tag, "_ready"}, cpu_res[0], 1'b1);
    e = exp_q.pop_front();
    check({tag, "_data"}, cpu_res[32:1], e);
    check({tag, "_memidle"}, mem_req, 162'h0);
    if (hit_exp) check({tag, "_hitlat"}, k, 1);
    else         check({tag, "_misslat"}, k > 1, 1'b1);
  endtask

  task automatic check_log(input string tag, input int idx, input logic [31:0] a,
                           input logic rw, input logic [127:0] d);
    if (mlog.size() > idx) begin
      check({tag, "_addr"}, mlog[idx].a, a);
      check({tag, "_rw"}, mlog[idx].rw, rw);
      if (rw) check({tag, "_wdata"}, mlog[idx].d, d);
    end
  endtask

  initial begin
    int k;
    rst     = 1'b0;
    cpu_req = '0;
    mem_rdata = '0;
    mem_rdy   = 1'b0;
    mcnt = 0;
    mlat = 2;
    mem[32'h0000_0000] = {4{32'h1111_1111}};
    mem[32'h0000_4000] = 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA;
    mem[32'h0000_0010] = 128'h44444444_33333333_22222222_EEEEEEEE;

    // Reset state
    #12;
    check("rst_cpu_res", cpu_res, 33'h0);
    check("rst_mem_req", mem_req, 162'h0);
    @(negedge clk) rst = 1'b1;
    @(negedge clk);
    check("idle_mem_req", mem_req, 162'h0);

    // Read miss, then read hit on the same line
    access("rd_miss", 32'h0, 32'h0, 1'b0, 32'h1111_1111, 1'b0);
    check("rd_miss_log_n", mlog.size(), 1);
    check_log("rd_miss_log", 0, 32'h0, 1'b0, '0);
    access("rd_hit", 32'h0, 32'h0, 1'b0, 32'h1111_1111, 1'b1);
    check("rd_hit_log_n", mlog.size(), 0);

    // Invalidate via reset, then write miss
    @(negedge clk) rst = 1'b0;
    @(negedge clk) rst = 1'b1;
    access("wr_miss", 32'h0, 32'h1111_1111, 1'b1, 32'h1111_1111, 1'b0);
    check("wr_miss_log_n", mlog.size(), 1);
    check_log("wr_miss_log", 0, 32'h0, 1'b0, '0);

    // Write hit, then read back the new word
    access("wr_hit", 32'h0, 32'h0, 1'b1, 32'h0, 1'b1);
    check("wr_hit_log_n", mlog.size(), 0);
    access("rd_after_wr", 32'h0, 32'h0, 1'b0, 32'h0, 1'b1);

    // Dirty eviction: same index, tag 1
    access("evict", 32'h4000, 32'h0, 1'b0, 32'hAAAA_AAAA, 1'b0);
    check("evict_log_n", mlog.size(), 2);
    check_log("evict_wb", 0, 32'h0, 1'b1, 128'h11111111_11111111_11111111_00000000);
    check_log("evict_alloc", 1, 32'h4000, 1'b0, '0);
    check("evict_mem0", mem[32'h0], 128'h11111111_11111111_11111111_00000000);

    // Other words of the refilled line, write hit to the last word
    access("rd_w2", 32'h4008, 32'h0, 1'b0, 32'hCCCC_CCCC, 1'b1);
    access("wr_w3", 32'h400C, 32'h1234_5678, 1'b1, 32'h1234_5678, 1'b1);
    access("rd_w3", 32'h400F, 32'h0, 1'b0, 32'h1234_5678, 1'b1);

    // Clean miss on another index
    access("rd_idx1", 32'h14, 32'h0, 1'b0, 32'h2222_2222, 1'b0);
    check("rd_idx1_log_n", mlog.size(), 1);
    check_log("rd_idx1_log", 0, 32'h10, 1'b0, '0);

    // Async reset while a refill is pending
    @(negedge clk);
    cpu_req = {32'h20, 32'h0, 1'b0, 1'b1};
    @(posedge clk);
    #1 cpu_req[0] = 1'b0;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!mem_req[0] && k < 20);
    check("abort_alloc_valid", mem_req[0], 1'b1);
    check("abort_alloc_addr", mem_req[161:130], 32'h20);
    #2 rst = 1'b0;
    #1;
    check("abort_mem_req", mem_req, 162'h0);
    check("abort_cpu_res", cpu_res, 33'h0);
    @(negedge clk) rst = 1'b1;

    // Everything invalid again: 0x4 misses and fetches the written-back line
    access("post_rst", 32'h4, 32'h0, 1'b0, 32'h1111_1111, 1'b0);
    check("post_rst_log_n", mlog.size(), 1);
    check_log("post_rst_log", 0, 32'h0, 1'b0, '0);
    access("post_rst_w0", 32'h0, 32'h0, 1'b0, 32'h0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
